// File: rtl/rv_muldiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath: accepts one
// M-extension op, counts its iterations, runs a sign-fix cycle, then holds the result.
module rv_muldiv_ctrl #(
  parameter int MUL_STEPS = 32,
  parameter int DIV_STEPS = 33,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_flush,
  input  logic       i_valid,
  input  logic [2:0] i_funct3,
  input  logic       i_div_zero,
  input  logic       i_div_ovf,
  input  logic       i_res_ready,
  output logic       o_ready,
  output logic       o_load,
  output logic       o_step,
  output logic       o_last,
  output logic       o_is_div,
  output logic       o_fix,
  output logic       o_signed,
  output logic [1:0] o_res_sel,
  output logic [5:0] o_cnt,
  output logic       o_valid,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_STEPS - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_STEPS - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] res_sel_q, res_sel_d;
  logic       is_div_q, is_div_d;
  logic       signed_q, signed_d;
  logic       last;

  assign last = (state_q == RUN) && (cnt_q == (is_div_q ? DIV_LAST : MUL_LAST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_sel_d = res_sel_q;
    is_div_d  = is_div_q;
    signed_d  = signed_q;
    if (i_flush) begin
      state_d   = IDLE;
      cnt_d     = 6'd0;
      res_sel_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            is_div_d = i_funct3[2];
            signed_d = i_funct3[2] ? !i_funct3[0] : (i_funct3[1:0] != 2'b11);
            // Divide-by-zero outranks overflow; overflow only exists for signed divide.
            if (EARLY_OUT && i_funct3[2] && i_div_zero) begin
              state_d   = DONE;
              res_sel_d = 2'd1;
            end else if (EARLY_OUT && i_funct3[2] && !i_funct3[0] && i_div_ovf) begin
              state_d   = DONE;
              res_sel_d = 2'd2;
            end else begin
              state_d   = RUN;
              cnt_d     = 6'd0;
              res_sel_d = 2'd0;
            end
          end
        end
        RUN: begin
          if (last) begin
            state_d = FIX;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        FIX:     state_d = DONE;
        DONE:    if (i_res_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      res_sel_q <= 2'd0;
      is_div_q  <= 1'b0;
      signed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_sel_q <= res_sel_d;
      is_div_q  <= is_div_d;
      signed_q  <= signed_d;
    end
  end

  // Flush gates the datapath strobes in the same cycle it is raised.
  assign o_ready   = (state_q == IDLE) && !i_flush;
  assign o_load    = i_valid && (state_q == IDLE) && !i_flush;
  assign o_step    = (state_q == RUN) && !i_flush;
  assign o_last    = last;
  assign o_fix     = (state_q == FIX) && !i_flush;
  assign o_valid   = (state_q == DONE) && !i_flush;
  assign o_busy    = (state_q != IDLE);
  assign o_is_div  = is_div_q;
  assign o_signed  = signed_q;
  assign o_res_sel = res_sel_q;
  assign o_cnt     = cnt_q;

endmodule

// File: tb/tb_rv_muldiv_ctrl.sv
// Directed bench for rv_muldiv_ctrl: one early-out build and one iterate-always build.
module tb_rv_muldiv_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset, i_flush, i_valid, i_div_zero, i_div_ovf, i_res_ready;
  logic [2:0] i_funct3;

  logic       o_ready, o_load, o_step, o_last, o_is_div, o_fix, o_signed, o_valid, o_busy;
  logic [1:0] o_res_sel;
  logic [5:0] o_cnt;

  logic       z_ready, z_load, z_step, z_last, z_is_div, z_fix, z_signed, z_valid, z_busy;
  logic [1:0] z_res_sel;
  logic [5:0] z_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  rv_muldiv_ctrl #(.MUL_STEPS(32), .DIV_STEPS(33), .EARLY_OUT(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .i_funct3(i_funct3), .i_div_zero(i_div_zero), .i_div_ovf(i_div_ovf),
    .i_res_ready(i_res_ready), .o_ready(o_ready), .o_load(o_load), .o_step(o_step),
    .o_last(o_last), .o_is_div(o_is_div), .o_fix(o_fix), .o_signed(o_signed),
    .o_res_sel(o_res_sel), .o_cnt(o_cnt), .o_valid(o_valid), .o_busy(o_busy)
  );

  rv_muldiv_ctrl #(.MUL_STEPS(32), .DIV_STEPS(33), .EARLY_OUT(1'b0)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .i_funct3(i_funct3), .i_div_zero(i_div_zero), .i_div_ovf(i_div_ovf),
    .i_res_ready(i_res_ready), .o_ready(z_ready), .o_load(z_load), .o_step(z_step),
    .o_last(z_last), .o_is_div(z_is_div), .o_fix(z_fix), .o_signed(z_signed),
    .o_res_sel(z_res_sel), .o_cnt(z_cnt), .o_valid(z_valid), .o_busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " busy"},    32'(o_busy),    32'd0);
    chk({tag, " cnt"},     32'(o_cnt),     32'd0);
    chk({tag, " res_sel"}, 32'(o_res_sel), 32'd0);
    chk({tag, " is_div"},  32'(o_is_div),  32'd0);
    chk({tag, " signed"},  32'(o_signed),  32'd0);
    chk({tag, " valid"},   32'(o_valid),   32'd0);
    chk({tag, " step"},    32'(o_step),    32'd0);
    chk({tag, " fix"},     32'(o_fix),     32'd0);
    chk({tag, " ready"},   32'(o_ready),   32'd1);
  endtask

  // Issues one op from IDLE and walks it to DONE, leaving the result unconsumed.
  task automatic run_op(input logic [2:0] f3, input logic dz, input logic ovf,
                        input int steps, input logic [1:0] sel, input logic sgn,
                        input string tag);
    i_valid = 1'b1; i_funct3 = f3; i_div_zero = dz; i_div_ovf = ovf;
    #1;
    chk({tag, " load"}, 32'(o_load), 32'd1);
    tick();
    i_valid = 1'b0; i_div_zero = 1'b0; i_div_ovf = 1'b0;
    #1;
    for (int k = 0; k < steps; k++) begin
      chk({tag, " step"}, 32'(o_step), 32'd1);
      chk({tag, " cnt"},  32'(o_cnt),  32'(k));
      chk({tag, " last"}, 32'(o_last), (k == steps - 1) ? 32'd1 : 32'd0);
      chk({tag, " nvalid"}, 32'(o_valid), 32'd0);
      tick();
    end
    if (steps > 0) begin
      chk({tag, " fix"},      32'(o_fix),  32'd1);
      chk({tag, " fix_step"}, 32'(o_step), 32'd0);
      chk({tag, " fix_cnt"},  32'(o_cnt),  32'd0);
      tick();
    end
    chk({tag, " valid"},   32'(o_valid),   32'd1);
    chk({tag, " res_sel"}, 32'(o_res_sel), 32'(sel));
    chk({tag, " signed"},  32'(o_signed),  32'(sgn));
    chk({tag, " is_div"},  32'(o_is_div),  32'(f3[2]));
    chk({tag, " d_step"},  32'(o_step),    32'd0);
    chk({tag, " d_ready"}, 32'(o_ready),   32'd0);
  endtask

  task automatic release_res(input string tag);
    i_res_ready = 1'b1;
    #1;
    chk({tag, " rel_valid"}, 32'(o_valid), 32'd1);
    tick();
    i_res_ready = 1'b0;
    #1;
    chk({tag, " rel_idle"},  32'(o_busy),  32'd0);
    chk({tag, " rel_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_funct3 = 3'd0;
    i_div_zero = 1'b0; i_div_ovf = 1'b0; i_res_ready = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    #1;
    chk_reset_state("reset");

    run_op(3'b000, 1'b0, 1'b0, 32, 2'd0, 1'b1, "mul");
    release_res("mul");

    run_op(3'b101, 1'b0, 1'b0, 33, 2'd0, 1'b0, "divu");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("divu hold", 32'(o_valid), 32'd1);
    end
    release_res("divu");

    run_op(3'b100, 1'b1, 1'b1, 0, 2'd1, 1'b1, "div_zero");
    release_res("div_zero");

    run_op(3'b100, 1'b0, 1'b1, 0, 2'd2, 1'b1, "div_ovf");
    // Flush together with res_ready in DONE: result is dropped, not consumed.
    i_flush = 1'b1; i_res_ready = 1'b1;
    #1;
    chk("flush_done valid", 32'(o_valid), 32'd0);
    tick();
    i_flush = 1'b0; i_res_ready = 1'b0;
    #1;
    chk("flush_done idle",    32'(o_busy),    32'd0);
    chk("flush_done res_sel", 32'(o_res_sel), 32'd0);

    run_op(3'b101, 1'b0, 1'b1, 33, 2'd0, 1'b0, "divu_ovf");
    release_res("divu_ovf");

    run_op(3'b011, 1'b0, 1'b0, 32, 2'd0, 1'b0, "mulhu");
    release_res("mulhu");

    // Flush at o_cnt==10 during MULH.
    i_valid = 1'b1; i_funct3 = 3'b001;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("flush pre_cnt", 32'(o_cnt), 32'd10);
    i_flush = 1'b1; i_valid = 1'b1;
    #1;
    chk("flush step",  32'(o_step),  32'd0);
    chk("flush load",  32'(o_load),  32'd0);
    chk("flush ready", 32'(o_ready), 32'd0);
    tick();
    i_flush = 1'b0; i_funct3 = 3'b010;
    #1;
    chk("flush idle",  32'(o_busy),  32'd0);
    chk("flush cnt",   32'(o_cnt),   32'd0);
    chk("flush ready", 32'(o_ready), 32'd1);
    chk("reaccept load", 32'(o_load), 32'd1);
    tick();
    // i_valid remains high while running: must not reload.
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid load", 32'(o_load), 32'd0);
      chk("hold_valid step", 32'(o_step), 32'd1);
      chk("hold_valid cnt",  32'(o_cnt),  32'(k));
      tick();
    end
    chk("mulhsu signed", 32'(o_signed), 32'd1);
    i_valid = 1'b0;
    i_reset = 1'b1; i_flush = 1'b1;
    tick();
    i_reset = 1'b0; i_flush = 1'b0;
    #1;
    chk_reset_state("mid_reset");

    // Iterate-always build: divide-by-zero takes the full divide sequence.
    i_valid = 1'b1; i_funct3 = 3'b110; i_div_zero = 1'b1;
    #1;
    chk("eo0 load", 32'(z_load), 32'd1);
    tick();
    i_valid = 1'b0; i_div_zero = 1'b0;
    #1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (z_valid) break;
      if (z_step) n++;
      tick();
    end
    chk("eo0 valid",   32'(z_valid),   32'd1);
    chk("eo0 steps",   32'(n),         32'd33);
    chk("eo0 res_sel", 32'(z_res_sel), 32'd0);
    chk("eo0 is_div",  32'(z_is_div),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
